ring_link_tx: RTL and testbench

- Transmit-side controller for one router output link in the bidirectional ring.
- Drains two upstream depth-1 channel buffers: forward (ring traffic) and local (PE injection).
- Reads via the buffers' read-enable/empty interface; arbitrates round-robin between them.
- Drives the downstream router's input buffer through a send/ready handshake.
- Is the reading end of the channel buffer and the writing end of the next hop's buffer.

---
 rtl/ring_link_tx_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 33 +++
 rtl/ring_link_tx.sv | 108 ++++++++++
 tb/tb_ring_link_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ring_link_tx_pkg.sv
// ring_link_tx_pkg: shared definitions for the ring link transmit controller.
//   state_t       : FSM state encoding (IDLE/READ/CAPTURE/SEND, 2 bits)
//   SRC_FWD/LOC   : source select values (index into the request vector)
//   DEFAULT_WIDTH : default packet width in bits
package ring_link_tx_pkg;

   localparam int DEFAULT_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2,
      SEND    = 2'd3
   } state_t;

   localparam logic SRC_FWD = 1'b0;
   localparam logic SRC_LOC = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter with registered last grant.
//   clk, reset : clock, async active-high reset (last grant resets to SRC_LOC)
//   req[1:0]   : requests, indexed by SRC_FWD / SRC_LOC
//   update     : commit the current grant as the new last grant
//   grant      : combinational winner (valid only while any_req=1)
//   any_req    : at least one requester active
module rr_arbiter2
   import ring_link_tx_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic       grant,
   output logic       any_req
);

   logic last;

   always_comb begin
      if (req[SRC_FWD] && req[SRC_LOC]) grant = ~last;
      else if (req[SRC_LOC])            grant = SRC_LOC;
      else                              grant = SRC_FWD;
   end

   assign any_req = |req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  last <= SRC_LOC;
      else if (update && any_req) last <= grant;
   end

endmodule

// File: rtl/ring_link_tx.sv
// ring_link_tx: transmit controller for one ring router output link.
// Drains the forward and local depth-1 channel buffers (round-robin) and
// hands each packet to the downstream buffer over a send/ready handshake.
//   clk, reset              : clock, async active-high reset
//   fwdEmpty/fwdData        : forward buffer status and registered dataOut
//   fwdRdEnable             : forward buffer read enable
//   locEmpty/locData        : local buffer status and registered dataOut
//   locRdEnable             : local buffer read enable
//   so, ri, dout            : send-valid, downstream ready, packet
//   fwdCount, locCount      : packets transmitted per source (wrapping)
//   busy                    : FSM not in IDLE
module ring_link_tx
   import ring_link_tx_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fwdEmpty,
   input  logic [WIDTH-1:0]     fwdData,
   output logic                 fwdRdEnable,
   input  logic                 locEmpty,
   input  logic [WIDTH-1:0]     locData,
   output logic                 locRdEnable,
   output logic                 so,
   input  logic                 ri,
   output logic [WIDTH-1:0]     dout,
   output logic [CNT_WIDTH-1:0] fwdCount,
   output logic [CNT_WIDTH-1:0] locCount,
   output logic                 busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   state_t state, state_nxt;
   logic   sel;          // source granted for the packet in flight
   logic   arb_grant;
   logic   arb_any;
   logic   arb_update;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({~locEmpty, ~fwdEmpty}),
      .update  (arb_update),
      .grant   (arb_grant),
      .any_req (arb_any)
   );

   // Arbitration happens in IDLE and on the completing SEND edge, so
   // back-to-back packets skip IDLE entirely.
   always_comb begin
      state_nxt   = state;
      arb_update  = 1'b0;
      fwdRdEnable = 1'b0;
      locRdEnable = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               arb_update = 1'b1;
               state_nxt  = READ;
            end
         end
         READ: begin
            fwdRdEnable = (sel == SRC_FWD);
            locRdEnable = (sel == SRC_LOC);
            state_nxt   = CAPTURE;
         end
         CAPTURE: state_nxt = SEND;
         SEND: begin
            if (ri) begin
               if (arb_any) begin
                  arb_update = 1'b1;
                  state_nxt  = READ;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // so is decoded from state so that reset drops it immediately.
   assign so   = (state == SEND);
   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sel      <= SRC_FWD;
         dout     <= '0;
         fwdCount <= '0;
         locCount <= '0;
      end else begin
         state <= state_nxt;
         if (arb_update) sel <= arb_grant;
         // Buffer dataOut is valid the cycle after the READ edge.
         if (state == CAPTURE) dout <= (sel == SRC_LOC) ? locData : fwdData;
         if (state == SEND && ri) begin
            if (sel == SRC_FWD) fwdCount <= fwdCount + CNT_ONE;
            else                locCount <= locCount + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_ring_link_tx.sv
// tb_ring_link_tx: directed bench for ring_link_tx. Two instances share the
// stimulus: the default one (16-bit counters) and one with 4-bit counters
// for the wrap case. Depth-1 channel buffers are modelled in the bench.
module tb_ring_link_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ri = 1'b1;
   logic        fwdEmpty, locEmpty;
   logic [63:0] fwdData = '0, locData = '0;
   logic        fwdRdEnable, locRdEnable, so, busy;
   logic [63:0] dout;
   logic [15:0] fwdCount, locCount;
   logic        n_fwdRd, n_locRd, n_so, n_busy;
   logic [63:0] n_dout;
   logic [3:0]  n_fwdCount, n_locCount;

   always #5 clk = ~clk;

   ring_link_tx #(.WIDTH(64), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .fwdEmpty(fwdEmpty), .fwdData(fwdData), .fwdRdEnable(fwdRdEnable),
      .locEmpty(locEmpty), .locData(locData), .locRdEnable(locRdEnable),
      .so(so), .ri(ri), .dout(dout),
      .fwdCount(fwdCount), .locCount(locCount), .busy(busy)
   );

   ring_link_tx #(.WIDTH(64), .CNT_WIDTH(4)) dut_n (
      .clk(clk), .reset(reset),
      .fwdEmpty(fwdEmpty), .fwdData(fwdData), .fwdRdEnable(n_fwdRd),
      .locEmpty(locEmpty), .locData(locData), .locRdEnable(n_locRd),
      .so(n_so), .ri(ri), .dout(n_dout),
      .fwdCount(n_fwdCount), .locCount(n_locCount), .busy(n_busy)
   );

   // Depth-1 buffer model; auto mode refills on every read so the source
   // stays non-empty.
   logic        fwd_full = 0, loc_full = 0;
   logic [63:0] fwd_mem = '0, loc_mem = '0;
   logic        fwd_push = 0, loc_push = 0, fwd_auto = 0, loc_auto = 0;
   logic [63:0] fwd_pdata = '0, loc_pdata = '0;

   assign fwdEmpty = ~fwd_full;
   assign locEmpty = ~loc_full;

   always @(posedge clk) begin
      if (fwdRdEnable) begin
         fwdData <= fwd_mem;
         if (fwd_auto) fwd_mem <= fwd_mem + 64'd1;
         else          fwd_full <= 1'b0;
      end
      if (fwd_push) begin fwd_full <= 1'b1; fwd_mem <= fwd_pdata; end
      if (locRdEnable) begin
         locData <= loc_mem;
         if (loc_auto) loc_mem <= loc_mem + 64'd1;
         else          loc_full <= 1'b0;
      end
      if (loc_push) begin loc_full <= 1'b1; loc_mem <= loc_pdata; end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Called at a negedge; buffers go full on the next posedge.
   task automatic push(input logic f, input logic l, input logic [63:0] fd, input logic [63:0] ld);
      fwd_push = f; loc_push = l; fwd_pdata = fd; loc_pdata = ld;
      @(negedge clk);
      fwd_push = 0; loc_push = 0;
   endtask

   task automatic rst_pulse();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic drain();
      ri = 1'b1; fwd_auto = 0; loc_auto = 0;
      for (int i = 0; i < 40 && !(fwdEmpty && locEmpty && !busy); i++) @(negedge clk);
      chk("drain_idle", {63'd0, fwdEmpty && locEmpty && !busy}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_cnt, rd_at, so_at, ng, both, bad, n;
      int seq[8];
      logic [63:0] so_dout;

      repeat (2) @(negedge clk);
      chk("rst_so",    {63'd0, so}, 64'd0);
      chk("rst_fwdrd", {63'd0, fwdRdEnable}, 64'd0);
      chk("rst_locrd", {63'd0, locRdEnable}, 64'd0);
      chk("rst_busy",  {63'd0, busy}, 64'd0);
      chk("rst_dout",  dout, 64'd0);
      chk("rst_fcnt",  {48'd0, fwdCount}, 64'd0);
      chk("rst_lcnt",  {48'd0, locCount}, 64'd0);
      reset = 1'b0;

      // single forward packet: READ at N2, SEND visible at N4
      push(1, 0, 64'hA5A5_0000_0000_0001, 64'd0);
      rd_cnt = 0; rd_at = -1; so_at = -1; so_dout = '0;
      for (int i = 2; i <= 8; i++) begin
         tick();
         if (fwdRdEnable) begin rd_cnt++; if (rd_at < 0) rd_at = i; end
         if (so && so_at < 0) begin so_at = i; so_dout = dout; end
      end
      chk("t1_rd_cnt", 64'(rd_cnt), 64'd1);
      chk("t1_rd_at",  64'(rd_at), 64'd2);
      chk("t1_so_at",  64'(so_at), 64'd4);
      chk("t1_dout",   so_dout, 64'hA5A5_0000_0000_0001);
      chk("t1_fcnt",   {48'd0, fwdCount}, 64'd1);
      chk("t1_lcnt",   {48'd0, locCount}, 64'd0);
      chk("t1_idle",   {63'd0, busy}, 64'd0);

      // both sources continuously busy: strict alternation, 3 cycles/packet
      rst_pulse();
      fwd_auto = 1; loc_auto = 1;
      push(1, 1, 64'd100, 64'd200);
      ng = 0; both = 0;
      for (int i = 2; i <= 19; i++) begin
         tick();
         if (fwdRdEnable && locRdEnable) both++;
         if (fwdRdEnable && ng < 8) begin seq[ng] = 0; ng++; end
         if (locRdEnable && ng < 8) begin seq[ng] = 1; ng++; end
         if (i == 4)  chk("t2_dout_f0", dout, 64'd100);
         if (i == 7)  chk("t2_dout_l0", dout, 64'd200);
         if (i == 10) chk("t2_dout_f1", dout, 64'd101);
      end
      tick();
      chk("t2_grants", 64'(ng), 64'd6);
      for (int j = 0; j < 6; j++) chk("t2_rr_order", 64'(seq[j]), 64'(j % 2));
      chk("t2_both_rd", 64'(both), 64'd0);
      chk("t2_fcnt", {48'd0, fwdCount}, 64'd3);
      chk("t2_lcnt", {48'd0, locCount}, 64'd3);
      drain();

      // local packet under 10 cycles of backpressure
      rst_pulse();
      ri = 1'b0;
      push(0, 1, 64'd0, 64'h1234);
      tick();
      chk("t3_locrd", {63'd0, locRdEnable}, 64'd1);
      tick();
      bad = 0;
      for (int i = 4; i <= 13; i++) begin
         tick();
         if (!so || dout != 64'h1234 || locCount != 16'd0 || fwdRdEnable || locRdEnable) bad++;
      end
      chk("t3_stall", 64'(bad), 64'd0);
      ri = 1'b1;
      tick();
      chk("t3_lcnt", {48'd0, locCount}, 64'd1);
      chk("t3_so_off", {63'd0, so}, 64'd0);
      chk("t3_dout_kept", dout, 64'h1234);
      chk("t3_idle", {63'd0, busy}, 64'd0);

      // async reset mid-SEND; the fwd grant just moved last grant to FWD
      ri = 1'b0;
      push(1, 0, 64'hBEEF, 64'd0);
      repeat (3) tick();
      chk("t4_in_send", {63'd0, so}, 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("t4_so",    {63'd0, so}, 64'd0);
      chk("t4_fwdrd", {63'd0, fwdRdEnable}, 64'd0);
      chk("t4_locrd", {63'd0, locRdEnable}, 64'd0);
      chk("t4_dout",  dout, 64'd0);
      chk("t4_lcnt",  {48'd0, locCount}, 64'd0);
      chk("t4_fcnt",  {48'd0, fwdCount}, 64'd0);
      chk("t4_busy",  {63'd0, busy}, 64'd0);
      @(negedge clk);
      reset = 1'b0; ri = 1'b1;
      push(1, 1, 64'hF1, 64'hE1);
      tick();
      chk("t4_fwd_first", {62'd0, fwdRdEnable, locRdEnable}, 64'd2);
      drain();

      // 17 local packets: 4-bit counter wraps to 1
      rst_pulse();
      loc_auto = 1;
      push(0, 1, 64'd0, 64'd0);
      n = 0;
      for (int i = 0; i < 120 && !(n == 17 && !busy); i++) begin
         tick();
         if (locRdEnable) begin
            n++;
            if (n == 17) loc_auto = 0;
         end
      end
      chk("t5_reads", 64'(n), 64'd17);
      chk("t5_lcnt16", {48'd0, locCount}, 64'd17);
      chk("t5_lcnt4",  {60'd0, n_locCount}, 64'd1);
      chk("t5_fcnt4",  {60'd0, n_fwdCount}, 64'd0);
      drain();

      // local arrives during fwd stall: READ follows the transfer directly
      rst_pulse();
      ri = 1'b0;
      push(1, 0, 64'hF00D, 64'd0);
      repeat (3) tick();
      push(0, 1, 64'd0, 64'hCAFE);
      repeat (2) tick();
      ri = 1'b1;
      tick();
      chk("t6_fcnt",  {48'd0, fwdCount}, 64'd1);
      chk("t6_rd",    {62'd0, fwdRdEnable, locRdEnable}, 64'd1);
      chk("t6_busy",  {63'd0, busy}, 64'd1);
      repeat (2) tick();
      chk("t6_so",    {63'd0, so}, 64'd1);
      chk("t6_dout",  dout, 64'hCAFE);
      tick();
      chk("t6_lcnt",  {48'd0, locCount}, 64'd1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
